// File: rtl/text_to_bcd_3.sv
// ============================================================================
//  Module      : text_to_bcd_3
//  Description : Serial ASCII-to-BCD entry parser. Takes one ASCII character
//                per handshake, collects up to three decimal digits and, on
//                the terminator, delivers a 10-bit packed BCD value
//                ({hundreds[1:0], tens[3:0], ones[3:0]}, range 000-399).
//                Malformed entries produce a one-cycle error pulse with a
//                cause code. A mid-entry idle timeout aborts stale entries.
//  Options     : `define TEXT_TO_BCD_BACKSPACE_EN makes 0x08 delete the last
//                digit; otherwise 0x08 is an illegal character.
//  Ports       : clk        - system clock, rising edge
//                reset      - synchronous, active-high reset
//                char_in    - ASCII character
//                char_valid - char_in is valid
//                char_ready - parser can accept a character (low in DONE)
//                bcd_data   - packed BCD result, holds last delivered value
//                bcd_valid  - bcd_data valid, held until bcd_ready
//                bcd_ready  - consumer accepts bcd_data
//                err        - one-cycle error pulse
//                err_code   - 00 empty, 01 illegal, 10 overflow, 11 timeout
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_to_bcd_3 #(
    parameter logic [7:0]  TERM_CHAR      = 8'h0D,
    parameter logic [7:0]  CLEAR_CHAR     = 8'h1B,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [9:0] bcd_data,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       err,
    output logic [1:0] err_code
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the fault fires on the
    // edge where it would otherwise advance past that value.
    localparam int unsigned     c_tmo_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last =
        (TIMEOUT_CYCLES > 0) ? c_tmo_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit              c_tmo_en   = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_err_empty    = 2'b00;
    localparam logic [1:0] c_err_illegal  = 2'b01;
    localparam logic [1:0] c_err_overflow = 2'b10;
    localparam logic [1:0] c_err_timeout  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_hund;
    logic [3:0]           r_tens;
    logic [3:0]           r_ones;
    logic [1:0]           r_cnt;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [9:0]           r_bcd_data;
    logic                 r_bcd_valid;
    logic                 r_err;
    logic [1:0]           r_err_code;

    logic       w_accept;
    logic       w_is_digit;
    logic       w_is_space;
    logic       w_is_term;
    logic       w_is_clear;
    logic       w_is_bs;
    logic [3:0] w_digit;
    logic       w_fault;
    logic [1:0] w_fault_code;

    assign char_ready = (r_state != S_DONE);
    assign w_accept   = char_valid && char_ready;
    assign w_digit    = char_in[3:0];
    assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_is_space = (char_in == 8'h20);
    assign w_is_term  = (char_in == TERM_CHAR);
    assign w_is_clear = (char_in == CLEAR_CHAR);

`ifdef TEXT_TO_BCD_BACKSPACE_EN
    assign w_is_bs = (char_in == 8'h08);
`else
    assign w_is_bs = 1'b0;
`endif

    // Error detection, evaluated in character-class priority order. All
    // error causes share the same recovery, so the sequential block only
    // needs to know whether and why.
    always_comb begin
        w_fault      = 1'b0;
        w_fault_code = c_err_empty;
        if (w_accept) begin
            if (w_is_digit) begin
                // A third digit is legal only if the leading digit fits in
                // the 2-bit hundreds field.
                if ((r_cnt == 2'd3) || ((r_cnt == 2'd2) && (r_tens > 4'd3))) begin
                    w_fault      = 1'b1;
                    w_fault_code = c_err_overflow;
                end
            end else if (w_is_space) begin
                if (r_cnt != 2'd0) begin
                    w_fault      = 1'b1;
                    w_fault_code = c_err_illegal;
                end
            end else if (w_is_term) begin
                if (r_cnt == 2'd0) begin
                    w_fault      = 1'b1;
                    w_fault_code = c_err_empty;
                end
            end else if (w_is_clear || w_is_bs) begin
                w_fault = 1'b0;
            end else begin
                w_fault      = 1'b1;
                w_fault_code = c_err_illegal;
            end
        end else if (c_tmo_en && (r_state == S_COLLECT) && (r_tmo == c_tmo_last)) begin
            w_fault      = 1'b1;
            w_fault_code = c_err_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hund      <= 2'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_cnt       <= 2'd0;
            r_tmo       <= '0;
            r_bcd_data  <= 10'h000;
            r_bcd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_err <= 1'b0;
            if (w_fault) begin
                r_state    <= S_IDLE;
                r_hund     <= 2'd0;
                r_tens     <= 4'd0;
                r_ones     <= 4'd0;
                r_cnt      <= 2'd0;
                r_tmo      <= '0;
                r_err      <= 1'b1;
                r_err_code <= w_fault_code;
            end else if (r_state == S_DONE) begin
                if (bcd_ready) begin
                    r_state     <= S_IDLE;
                    r_bcd_valid <= 1'b0;
                    r_hund      <= 2'd0;
                    r_tens      <= 4'd0;
                    r_ones      <= 4'd0;
                    r_cnt       <= 2'd0;
                    r_tmo       <= '0;
                end
            end else if (w_accept) begin
                r_tmo <= '0;
                if (w_is_digit) begin
                    // Shift digits left by one decimal place.
                    r_hund  <= r_tens[1:0];
                    r_tens  <= r_ones;
                    r_ones  <= w_digit;
                    r_cnt   <= r_cnt + 2'd1;
                    r_state <= S_COLLECT;
                end else if (w_is_space) begin
                    r_state <= r_state;
                end else if (w_is_term) begin
                    r_bcd_data  <= {r_hund, r_tens, r_ones};
                    r_bcd_valid <= 1'b1;
                    r_state     <= S_DONE;
                end else if (w_is_clear) begin
                    r_hund  <= 2'd0;
                    r_tens  <= 4'd0;
                    r_ones  <= 4'd0;
                    r_cnt   <= 2'd0;
                    r_state <= S_IDLE;
                end else if (w_is_bs) begin
                    if (r_cnt != 2'd0) begin
                        r_ones <= r_tens;
                        r_tens <= {2'b00, r_hund};
                        r_hund <= 2'd0;
                        r_cnt  <= r_cnt - 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            end else if (c_tmo_en && (r_state == S_COLLECT)) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign bcd_data  = r_bcd_data;
    assign bcd_valid = r_bcd_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_text_to_bcd_3.sv
// ============================================================================
//  Module      : tb_text_to_bcd_3
//  Description : Self-checking bench for text_to_bcd_3. A reference model
//                tracks the entry as a plain integer value and digit count
//                and predicts errors and delivered BCD values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_to_bcd_3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [9:0] bcd_data;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: entry as integer plus digit count.
    int         m_len  = 0;
    int         m_val  = 0;
    logic [9:0] m_last = 10'h000;
    bit         exp_err;
    logic [1:0] exp_code;
    bit         exp_valid;

    always #5 clk = ~clk;

    text_to_bcd_3 #(
        .TERM_CHAR      (8'h0D),
        .CLEAR_CHAR     (8'h1B),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .bcd_data   (bcd_data),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] to_bcd(input int v);
        return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_clear();
        m_len = 0;
        m_val = 0;
    endtask

    // Drive one character through the handshake and update the model.
    task automatic drive_char(input logic [7:0] c);
        int guard;
        int d;
        guard = 0;
        while (char_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (char_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL ready_wait char_ready=%b required 1", char_ready);
        end
        char_in    = c;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;

        exp_err   = 1'b0;
        exp_code  = 2'b00;
        exp_valid = 1'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            d = int'(c) - 48;
            if (m_len == 3 || (m_val * 10 + d) > 399) begin
                exp_err = 1'b1; exp_code = 2'b10; model_clear();
            end else begin
                m_val = m_val * 10 + d;
                m_len++;
            end
        end else if (c == 8'h20) begin
            if (m_len > 0) begin
                exp_err = 1'b1; exp_code = 2'b01; model_clear();
            end
        end else if (c == 8'h0D) begin
            if (m_len > 0) begin
                exp_valid = 1'b1;
                m_last    = to_bcd(m_val);
                model_clear();
            end else begin
                exp_err = 1'b1; exp_code = 2'b00;
            end
        end else if (c == 8'h1B) begin
            model_clear();
`ifdef TEXT_TO_BCD_BACKSPACE_EN
        end else if (c == 8'h08) begin
            if (m_len > 0) begin
                m_val = m_val / 10;
                m_len--;
            end
`endif
        end else begin
            exp_err = 1'b1; exp_code = 2'b01; model_clear();
        end
    endtask

    task automatic release_output();
        bcd_ready = 1'b1;
        tick();
        bcd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; char_valid = 1'b0; char_in = 8'h00; bcd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (bcd_data !== 10'h000) $display("FAIL reset_data bcd_data=%h required 000", bcd_data); else n_pass++;
        n_checks++; if (bcd_valid !== 1'b0) $display("FAIL reset_valid bcd_valid=%b required 0", bcd_valid); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_code !== 2'b00) $display("FAIL reset_err err=%b code=%b required 0/00", err, err_code); else n_pass++;
        n_checks++; if (char_ready !== 1'b1) $display("FAIL reset_ready char_ready=%b required 1", char_ready); else n_pass++;
    endtask

    task automatic test_basic();
        drive_char("1"); drive_char("2"); drive_char("5");
        n_checks++; if (err !== 1'b0 || bcd_valid !== 1'b0) $display("FAIL basic_digits err=%b valid=%b required 0/0", err, bcd_valid); else n_pass++;
        bcd_ready = 1'b1;
        drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h125) $display("FAIL basic_out valid=%b data=%h required 1/125", bcd_valid, bcd_data); else n_pass++;
        tick();
        bcd_ready = 1'b0;
        n_checks++; if (bcd_valid !== 1'b0 || char_ready !== 1'b1) $display("FAIL basic_release valid=%b ready=%b required 0/1", bcd_valid, char_ready); else n_pass++;
    endtask

    // Output hold and no character acceptance during DONE, including the
    // handshake edge itself.
    task automatic test_back_to_back();
        drive_char(" "); drive_char(" "); drive_char("7"); drive_char(8'h0D);
        char_in = "5"; char_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bcd_valid !== 1'b1 || char_ready !== 1'b0 || bcd_data !== 10'h007)
                $display("FAIL hold_%0d valid=%b ready=%b data=%h required 1/0/007", i, bcd_valid, char_ready, bcd_data);
            else n_pass++;
            tick();
        end
        bcd_ready = 1'b1;
        tick();
        bcd_ready = 1'b0; char_valid = 1'b0;
        n_checks++; if (bcd_valid !== 1'b0 || char_ready !== 1'b1) $display("FAIL hold_release valid=%b ready=%b required 0/1", bcd_valid, char_ready); else n_pass++;
        drive_char(8'h0D);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b00) $display("FAIL no_accept_in_done err=%b code=%b required 1/00", err, err_code); else n_pass++;
    endtask

    task automatic test_overflow();
        drive_char("4"); drive_char("5"); drive_char("6");
        n_checks++; if (err !== 1'b1 || err_code !== 2'b10) $display("FAIL ovf_456 err=%b code=%b required 1/10", err, err_code); else n_pass++;
        drive_char("1"); drive_char("2"); drive_char("3");
        n_checks++; if (err !== 1'b0) $display("FAIL ovf_123 err=%b required 0", err); else n_pass++;
        drive_char("4");
        n_checks++; if (err !== 1'b1 || err_code !== 2'b10) $display("FAIL ovf_1234 err=%b code=%b required 1/10", err, err_code); else n_pass++;
        drive_char("3"); drive_char("9"); drive_char("9"); drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h399) $display("FAIL max_399 valid=%b data=%h required 1/399", bcd_valid, bcd_data); else n_pass++;
        release_output();
        drive_char("0"); drive_char("1"); drive_char("2"); drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h012) $display("FAIL lead_zero valid=%b data=%h required 1/012", bcd_valid, bcd_data); else n_pass++;
        release_output();
    endtask

    task automatic test_errors();
        drive_char("A");
        n_checks++; if (err !== 1'b1 || err_code !== 2'b01) $display("FAIL err_alpha err=%b code=%b required 1/01", err, err_code); else n_pass++;
        tick();
        n_checks++; if (err !== 1'b0) $display("FAIL err_one_cycle err=%b required 0", err); else n_pass++;
        drive_char(8'h0D);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b00) $display("FAIL err_empty err=%b code=%b required 1/00", err, err_code); else n_pass++;
        drive_char("5"); drive_char(" ");
        n_checks++; if (err !== 1'b1 || err_code !== 2'b01) $display("FAIL err_space err=%b code=%b required 1/01", err, err_code); else n_pass++;
        drive_char("8"); drive_char(8'h1B);
        n_checks++; if (err !== 1'b0) $display("FAIL esc_quiet err=%b required 0", err); else n_pass++;
        drive_char(8'h0D);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b00 || bcd_data !== 10'h012) $display("FAIL esc_then_cr err=%b code=%b data=%h required 1/00/012", err, err_code, bcd_data); else n_pass++;
    endtask

    task automatic test_timeout();
        bit early;
        drive_char("3");
        early = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (err !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early) $display("FAIL tmo_early err seen before 20 idle cycles, required none"); else n_pass++;
        tick();
        model_clear();
        n_checks++; if (err !== 1'b1 || err_code !== 2'b11 || char_ready !== 1'b1) $display("FAIL tmo_fire err=%b code=%b ready=%b required 1/11/1", err, err_code, char_ready); else n_pass++;
        drive_char("3"); drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h003) $display("FAIL tmo_next valid=%b data=%h required 1/003", bcd_valid, bcd_data); else n_pass++;
        release_output();
    endtask

    task automatic test_reset_mid();
        drive_char("1"); drive_char("2");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        m_last = 10'h000;
        n_checks++;
        if (bcd_data !== 10'h000 || bcd_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'b00 || char_ready !== 1'b1)
            $display("FAIL reset_mid data=%h valid=%b err=%b code=%b ready=%b required 000/0/0/00/1", bcd_data, bcd_valid, err, err_code, char_ready);
        else n_pass++;
        drive_char("9"); drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h009) $display("FAIL reset_next valid=%b data=%h required 1/009", bcd_valid, bcd_data); else n_pass++;
        release_output();
    endtask

    task automatic test_backspace();
`ifdef TEXT_TO_BCD_BACKSPACE_EN
        drive_char("1"); drive_char("2"); drive_char(8'h08); drive_char("7"); drive_char(8'h0D);
        n_checks++; if (bcd_valid !== 1'b1 || bcd_data !== 10'h017) $display("FAIL bs_edit valid=%b data=%h required 1/017", bcd_valid, bcd_data); else n_pass++;
        release_output();
        drive_char(8'h08);
        n_checks++; if (err !== 1'b0) $display("FAIL bs_idle err=%b required 0", err); else n_pass++;
`else
        drive_char(8'h08);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b01) $display("FAIL bs_illegal err=%b code=%b required 1/01", err, err_code); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] c;
        int         sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 15));
            if (sel <= 9)       c = 8'h30 + 8'(sel);
            else if (sel == 10) c = 8'h20;
            else if (sel == 12) c = 8'h1B;
            else if (sel == 13) c = 8'h41 + 8'($urandom_range(0, 25));
            else if (sel == 14) c = 8'h08;
            else                c = 8'h0D;
            drive_char(c);
            n_checks++;
            if (err !== exp_err || (exp_err && err_code !== exp_code))
                $display("FAIL rnd_err_%0d char=%h err=%b code=%b required %b/%b", i, c, err, err_code, exp_err, exp_code);
            else n_pass++;
            n_checks++;
            if (bcd_valid !== exp_valid || bcd_data !== m_last)
                $display("FAIL rnd_out_%0d char=%h valid=%b data=%h required %b/%h", i, c, bcd_valid, bcd_data, exp_valid, m_last);
            else n_pass++;
            if (exp_valid) begin
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
                release_output();
                n_checks++;
                if (bcd_valid !== 1'b0 || char_ready !== 1'b1)
                    $display("FAIL rnd_rel_%0d valid=%b ready=%b required 0/1", i, bcd_valid, char_ready);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_backspace();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
